// File: rtl/systolic_ctrl_if.sv
// Job/array control bundle between a job master and the systolic controller.
// Carries job request, per-edge inject valids, feed index and drain handshake.
interface systolic_ctrl_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int KW   = 8
);
    localparam int IW = $clog2(COLS);

    logic            start;
    logic [KW-1:0]   k_len;
    logic            busy;
    logic            done;
    logic            err;
    logic            acc_clear;
    logic [ROWS-1:0] iact_valid;
    logic [COLS-1:0] weight_valid;
    logic [KW-1:0]   feed_addr;
    logic            shift_acc;
    logic            drain_in_valid;
    logic [IW-1:0]   drain_idx;

    modport master (
        output start, k_len, drain_in_valid,
        input  busy, done, err, acc_clear, iact_valid, weight_valid,
               feed_addr, shift_acc, drain_idx
    );

    modport slave (
        input  start, k_len, drain_in_valid,
        output busy, done, err, acc_clear, iact_valid, weight_valid,
               feed_addr, shift_acc, drain_idx
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Systolic array job sequencer: clear, skewed feed, capture, drain with timeout.
// All outputs registered; start is ignored while busy, drain waits on drain_in_valid.
module systolic_ctrl #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int KW   = 8
) (
    input  logic            clock,
    input  logic            reset,
    systolic_ctrl_if.slave  bus
);
    localparam int IW = $clog2(COLS);
    localparam int BW = $clog2(COLS + 1);
    localparam int TW = $clog2(2 * COLS + 1);
    localparam int CW = KW + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, SHIFT, DRAIN, DONE} state_e;

    state_e          state_q;
    logic [KW-1:0]   k_q;
    logic [CW-1:0]   t_q, t_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            last_feed;

    logic            busy_q, done_q, err_q, acc_clear_q, shift_acc_q;
    logic [ROWS-1:0] iact_q;
    logic [COLS-1:0] wgt_q;
    logic [KW-1:0]   feed_addr_q;
    logic [IW-1:0]   drain_idx_q;

    // Row r sees operand t-r, so it is live for t in [r, r+k-1]; empty when k=0.
    function automatic logic [ROWS-1:0] row_vld(input logic [CW-1:0] t, input logic [KW-1:0] k);
        logic [ROWS-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) v[r] = (int'(t) >= r) && (int'(t) < r + int'(k));
        return v;
    endfunction

    function automatic logic [COLS-1:0] col_vld(input logic [CW-1:0] t, input logic [KW-1:0] k);
        logic [COLS-1:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) v[c] = (int'(t) >= c) && (int'(t) < c + int'(k));
        return v;
    endfunction

    always_comb begin
        t_d    = t_q + 1'b1;
        beat_d = beat_q + 1'b1;
        tmo_d  = tmo_q + 1'b1;
    end

    assign last_feed = (int'(t_q) == int'(k_q) + ROWS + COLS - 3);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            t_q         <= '0;
            beat_q      <= '0;
            tmo_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            acc_clear_q <= 1'b0;
            shift_acc_q <= 1'b0;
            iact_q      <= '0;
            wgt_q       <= '0;
            feed_addr_q <= '0;
            drain_idx_q <= '0;
        end else begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            acc_clear_q <= 1'b0;
            shift_acc_q <= 1'b0;
            iact_q      <= '0;
            wgt_q       <= '0;
            feed_addr_q <= '0;
            drain_idx_q <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        k_q         <= bus.k_len;
                        state_q     <= CLEAR;
                        busy_q      <= 1'b1;
                        acc_clear_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_q <= FEED;
                    t_q     <= '0;
                    iact_q  <= row_vld('0, k_q);
                    wgt_q   <= col_vld('0, k_q);
                end
                FEED: begin
                    if (last_feed) begin
                        state_q     <= SHIFT;
                        shift_acc_q <= 1'b1;
                    end else begin
                        t_q         <= t_d;
                        iact_q      <= row_vld(t_d, k_q);
                        wgt_q       <= col_vld(t_d, k_q);
                        feed_addr_q <= t_d[KW-1:0];
                    end
                end
                SHIFT: begin
                    state_q <= DRAIN;
                    beat_q  <= '0;
                    tmo_q   <= '0;
                end
                DRAIN: begin
                    // Completion wins over timeout when the last beat lands on the final cycle.
                    if (bus.drain_in_valid && beat_q == BW'(COLS - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (tmo_q == TW'(2 * COLS - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_d;
                        if (bus.drain_in_valid) begin
                            beat_q      <= beat_d;
                            drain_idx_q <= beat_d[IW-1:0];
                        end else begin
                            drain_idx_q <= beat_q[IW-1:0];
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.acc_clear    = acc_clear_q;
    assign bus.shift_acc    = shift_acc_q;
    assign bus.iact_valid   = iact_q;
    assign bus.weight_valid = wgt_q;
    assign bus.feed_addr    = feed_addr_q;
    assign bus.drain_idx    = drain_idx_q;
endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: directed jobs push expected events,
// a negedge monitor reports observed events and compares them in order.
module tb_systolic_ctrl;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int KW   = 8;

    logic clock;
    logic reset;

    systolic_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .KW(KW)) bus ();

    systolic_ctrl #(.ROWS(ROWS), .COLS(COLS), .KW(KW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string name;
        int    cyc;
        int    val;
    } ev_t;

    ev_t expq[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  ec    = -1;
    int  base  = 0;
    logic rst_smp = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        ec      <= ec + 1;
        rst_smp <= reset;
    end

    // ---------------- scoreboard push helpers (job-relative cycle numbers)
    task automatic push_raw(input string nm, input int cyc, input int v);
        ev_t e;
        e.name = nm;
        e.cyc  = cyc;
        e.val  = v;
        expq.push_back(e);
    endtask

    task automatic expe(input string nm, input int c, input int v);
        push_raw(nm, base + c - 1, v);
    endtask

    task automatic expw(input string nm, input int c, input int wc);
        push_raw(nm, base + c - 1, base + wc - 1);
    endtask

    task automatic exp_k8(input int off);
        int s;
        s = 16 + off;
        expe("clr", 1 + off, 0);
        expe("shift", s, 14);
        expe("faddr", s, 13);
        expw("i0f", s, 2 + off);
        expw("i0l", s, 9 + off);
        expw("i3f", s, 5 + off);
        expw("i3l", s, 12 + off);
        expw("w3f", s, 5 + off);
        expw("w3l", s, 12 + off);
        expe("vcnt", s, 64);
    endtask

    task automatic exp_beats4(input int b);
        for (int i = 0; i < 4; i++) expe("beat", b + 1 + i, i);
    endtask

    task automatic exp_done(input int c, input int bn);
        expe("done", c, 1);
        expe("busyn", c, bn);
        expe("vpost", c, 0);
    endtask

    function automatic logic [63:0] mk(input int a, input int b, input int c, input int d);
        logic [63:0] m;
        m = '0;
        m[a] = 1'b1;
        m[b] = 1'b1;
        m[c] = 1'b1;
        m[d] = 1'b1;
        return m;
    endfunction

    // ---------------- stimulus
    task automatic begin_job();
        @(posedge clock);
        #1;
        base = ec + 1;
    endtask

    task automatic drive(input logic [KW-1:0] k, input int hold, input logic [63:0] m,
                         input int rst_c, input int n);
        bus.start          = 1'b1;
        bus.k_len          = k;
        bus.drain_in_valid = m[0];
        for (int c = 1; c <= n; c++) begin
            @(posedge clock);
            #1;
            bus.start          = (c <= hold);
            bus.k_len          = (c <= hold) ? k : 8'hAA;
            bus.drain_in_valid = (c < 64) ? m[c] : 1'b0;
            reset              = (c == rst_c);
        end
        bus.start          = 1'b0;
        bus.drain_in_valid = 1'b0;
        reset              = 1'b0;
    endtask

    // ---------------- monitor
    task automatic observe(input string nm, input int v);
        ev_t e;
        n_cmp++;
        if (expq.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got %0d at edge %0d, required no event", nm, v, ec);
        end else begin
            e = expq.pop_front();
            if (e.name != nm || e.cyc != ec || e.val != v) begin
                n_bad++;
                $display("FAIL %s: got %s@%0d=%0d, required %s@%0d=%0d",
                         nm, nm, ec, v, e.name, e.cyc, e.val);
            end
        end
    endtask

    int  busyn = 0, vcnt = 0, feed_n = 0, last_fa = 0;
    int  i0f = -1, i0l = -1, i3f = -1, i3l = -1, w3f = -1, w3l = -1;
    bit  in_feed = 0, in_drain = 0;

    always @(negedge clock) begin
        if (ec >= 0) begin
            if (rst_smp) begin
                observe("idle_out", int'({bus.busy, bus.done, bus.err, bus.acc_clear,
                                          bus.shift_acc, |bus.iact_valid, |bus.weight_valid,
                                          |bus.feed_addr, |bus.drain_idx}));
                busyn = 0; vcnt = 0; feed_n = 0; in_feed = 0; in_drain = 0;
            end else begin
                if (bus.busy) busyn++;
                vcnt += $countones(bus.iact_valid) + $countones(bus.weight_valid);
                if (bus.iact_valid[0])   begin if (i0f < 0) i0f = ec; i0l = ec; end
                if (bus.iact_valid[3])   begin if (i3f < 0) i3f = ec; i3l = ec; end
                if (bus.weight_valid[3]) begin if (w3f < 0) w3f = ec; w3l = ec; end
                if (bus.acc_clear) begin
                    observe("clr", 0);
                    in_feed = 1; feed_n = 0; vcnt = 0;
                    i0f = -1; i0l = -1; i3f = -1; i3l = -1; w3f = -1; w3l = -1;
                end else if (bus.shift_acc) begin
                    in_feed = 0;
                    observe("shift", feed_n);
                    observe("faddr", last_fa);
                    observe("i0f", i0f);
                    observe("i0l", i0l);
                    observe("i3f", i3f);
                    observe("i3l", i3l);
                    observe("w3f", w3f);
                    observe("w3l", w3l);
                    observe("vcnt", vcnt);
                    vcnt = 0;
                    in_drain = 1;
                end else if (in_feed) begin
                    feed_n++;
                    last_fa = int'(bus.feed_addr);
                end else if (in_drain && bus.drain_in_valid) begin
                    observe("beat", int'(bus.drain_idx));
                end
                if (bus.done) begin
                    observe("done", int'(bus.busy));
                    observe("busyn", busyn);
                    observe("vpost", vcnt);
                    in_drain = 0; busyn = 0;
                end
                if (bus.err) begin
                    observe("err", int'(bus.busy));
                    observe("busyn", busyn);
                    in_drain = 0; busyn = 0;
                end
            end
        end
    end

    // ---------------- directed jobs
    initial begin
        reset              = 1'b1;
        bus.start          = 1'b0;
        bus.k_len          = '0;
        bus.drain_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) push_raw("idle_out", i, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // nominal k=8
        begin_job();
        exp_k8(0); exp_beats4(16); exp_done(21, 21);
        drive(8'd8, 0, mk(17, 18, 19, 20), -1, 24);

        // k=0 drains zeros
        begin_job();
        expe("clr", 1, 0);
        expe("shift", 8, 6);
        expe("faddr", 8, 5);
        expe("i0f", 8, -1); expe("i0l", 8, -1);
        expe("i3f", 8, -1); expe("i3l", 8, -1);
        expe("w3f", 8, -1); expe("w3l", 8, -1);
        expe("vcnt", 8, 0);
        exp_beats4(8); exp_done(13, 13);
        drive(8'd0, 0, mk(9, 10, 11, 12), -1, 16);

        // gapped drain
        begin_job();
        exp_k8(0);
        expe("beat", 17, 0); expe("beat", 19, 1); expe("beat", 20, 2); expe("beat", 22, 3);
        exp_done(23, 23);
        drive(8'd8, 0, mk(17, 19, 20, 22), -1, 26);

        // drain timeout
        begin_job();
        exp_k8(0);
        expe("beat", 17, 0); expe("beat", 18, 1); expe("beat", 19, 2);
        expe("err", 25, 0); expe("busyn", 25, 24);
        drive(8'd8, 0, mk(17, 18, 19, 0), -1, 32);

        // start held high: second job accepted in cycle 22
        begin_job();
        exp_k8(0); exp_beats4(16); exp_done(21, 21);
        exp_k8(22); exp_beats4(38); exp_done(43, 21);
        drive(8'd8, 22, mk(17, 18, 19, 20) | mk(39, 40, 41, 42), -1, 46);

        // reset mid-FEED, then a fresh job
        begin_job();
        expe("clr", 1, 0);
        expe("idle_out", 11, 0);
        drive(8'd8, 0, '0, 10, 11);
        begin_job();
        exp_k8(0); exp_beats4(16); exp_done(21, 21);
        drive(8'd8, 0, mk(17, 18, 19, 20), -1, 24);

        repeat (5) @(posedge clock);
        #1;
        while (expq.size() > 0) begin
            ev_t e;
            e = expq.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got nothing, required event at edge %0d val %0d", e.name, e.cyc, e.val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
